// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package demux_stream_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Widest drop counter supported; narrower counters take the low bits.
    localparam int MAX_CNT_W = 32;

    // Saturation value for the drop counter (all ones, sliced to CNT_W).
    localparam logic [MAX_CNT_W-1:0] DROP_SAT = '1;

    // Select width for n channels, never below one bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with an EMPTY/FULL handshake state.
module demux_slot
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             avail_o
);

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SLOT_EMPTY;
        else        state_q <= state_d;
    end

    // Next state: load always wins; a drain without load empties the slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
            SLOT_FULL:  if (!load_i && ready_i) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Outputs: valid/data come from registers only; avail lets a draining slot refill.
    always_comb begin
        valid_o = (state_q == SLOT_FULL);
        avail_o = (state_q == SLOT_EMPTY) || ready_i;
        data_o  = data_q;
    end

    // Payload only changes on load, so it is stable while stalled.
    always_comb data_d = load_i ? data_i : data_q;

    // Payload register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

endmodule

// File: rtl/demux_stream_1_to_n.sv
// Registered 1-to-N stream demux with broadcast and counted drops of bad selects.
module demux_stream_1_to_n
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = sel_width(N_OUT),
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = DROP_SAT[CNT_W-1:0];

    logic [N_OUT-1:0] avail;
    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] load;
    logic             in_range;
    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // One-hot decode of the select; all zeros means the select is out of range.
    for (genvar k = 0; k < N_OUT; k++) begin : g_dec
        assign sel_hit[k] = (in_sel == SEL_W'(k));
    end

    // Accept/route: broadcast is all-or-nothing, bad unicast selects are swallowed.
    always_comb begin
        in_range = |sel_hit;
        if (in_bcast)      in_ready = &avail;
        else if (in_range) in_ready = |(sel_hit & avail);
        else               in_ready = 1'b1;
        accept = in_valid && in_ready;
        load   = '0;
        if (accept) load = in_bcast ? '1 : sel_hit;
        drop   = accept && !in_bcast && !in_range;
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .data_i  (in_data),
            .ready_i (out_ready[k]),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH]),
            .avail_o (avail[k])
        );
    end

    // Drop counter next value, holding at all ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != CNT_SAT) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1_to_n.sv
// Directed bench: 4-channel instance checked against a per-channel queue model,
// plus a 5-channel / 2-bit-counter instance for drop and broadcast-select cases.
module tb_demux_stream_1_to_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Four-channel instance
    logic        v, rdy, bc;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic [3:0]  ov, ordy;
    logic [31:0] od;
    logic [7:0]  dc;

    // Five-channel instance, 2-bit drop counter
    logic        v5, rdy5, bc5;
    logic [7:0]  d5;
    logic [2:0]  sel5;
    logic [4:0]  ov5, ordy5;
    logic [39:0] od5;
    logic [1:0]  dc5;

    demux_stream_1_to_n #(.WIDTH(8), .N_OUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v), .in_ready(rdy), .in_data(d),
        .in_sel(sel), .in_bcast(bc), .out_valid(ov), .out_ready(ordy),
        .out_data(od), .drop_cnt(dc)
    );

    demux_stream_1_to_n #(.WIDTH(8), .N_OUT(5), .SEL_W(3), .CNT_W(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5), .in_data(d5),
        .in_sel(sel5), .in_bcast(bc5), .out_valid(ov5), .out_ready(ordy5),
        .out_data(od5), .drop_cnt(dc5)
    );

    int nchk = 0;
    int npass = 0;
    int nfail = 0;

    // Scoreboard: expected contents of each channel slot
    logic [7:0] mq [4][$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the 4-channel instance: check at negedge, advance model at posedge.
    task automatic cycle(input string tag);
        logic [3:0] full, avl, ev;
        logic       er;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            full[k] = (mq[k].size() != 0);
            avl[k]  = !full[k] || ordy[k];
        end
        if (bc) er = &avl;
        else    er = avl[sel];
        ev = full;
        check({tag, "/in_ready"}, 64'(rdy), 64'(er));
        check({tag, "/out_valid"}, 64'(ov), 64'(ev));
        for (int k = 0; k < 4; k++)
            if (full[k]) check($sformatf("%s/data%0d", tag, k), 64'(od[k*8 +: 8]), 64'(mq[k][0]));
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (full[k] && ordy[k]) void'(mq[k].pop_front());
            if (v && er && (bc || sel == 2'(k))) mq[k].push_back(d);
        end
        #1;
    endtask

    initial begin
        v = 0; d = 0; sel = 0; bc = 0; ordy = 0;
        v5 = 0; d5 = 0; sel5 = 0; bc5 = 0; ordy5 = 0;

        // Reset state
        #12;
        check("rst/out_valid", 64'(ov), 64'h0);
        check("rst/out_data", 64'(od), 64'h0);
        check("rst/drop_cnt", 64'(dc), 64'h0);
        check("rst/in_ready", 64'(rdy), 64'h1);
        check("rst/out_valid5", 64'(ov5), 64'h0);
        check("rst/drop_cnt5", 64'(dc5), 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // First transfer to ch2
        v = 1; sel = 2; d = 8'hA5; ordy = 4'b0000;
        cycle("first");
        v = 0;
        cycle("first_out");
        check("first/ov", 64'(ov), 64'h4);
        check("first/ch2", 64'(od[23:16]), 64'hA5);
        ordy = 4'b0100;
        cycle("first_drain");

        // Backpressure on ch1
        v = 1; sel = 1; d = 8'h11; ordy = 4'b0000;
        cycle("bp_load");
        d = 8'h22;
        repeat (5) cycle("bp_stall");
        ordy = 4'b0010;
        cycle("bp_release");
        v = 0; ordy = 4'b0000;
        cycle("bp_new");
        check("bp/ch1", 64'(od[15:8]), 64'h22);
        ordy = 4'b1111;
        cycle("bp_drain");

        // Streaming 16 transfers into ch0
        v = 1; sel = 0; ordy = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            d = 8'(i);
            cycle($sformatf("stream%0d", i));
        end
        v = 0;
        cycle("stream_tail");
        cycle("stream_idle");

        // Broadcast blocked by stalled ch3
        v = 1; sel = 3; d = 8'h33; ordy = 4'b0000;
        cycle("bc_pre");
        bc = 1; d = 8'h5A; ordy = 4'b0111;
        cycle("bc_block");
        cycle("bc_block");
        ordy = 4'b1111;
        cycle("bc_go");
        v = 0; bc = 0; ordy = 4'b0000;
        cycle("bc_out");
        check("bc/all", 64'(od), 64'h5A5A5A5A);
        ordy = 4'b1111;
        cycle("bc_drain");
        ordy = 4'b0000;

        // Five-channel: broadcast with an out-of-range select is not a drop
        v5 = 1; bc5 = 1; sel5 = 3'd7; d5 = 8'h5A; ordy5 = 5'b00000;
        @(negedge clk);
        check("d5bc/in_ready", 64'(rdy5), 64'h1);
        @(posedge clk); #1;
        v5 = 0; bc5 = 0;
        @(negedge clk);
        check("d5bc/out_valid", 64'(ov5), 64'h1F);
        check("d5bc/out_data", 64'(od5), 64'h5A5A5A5A5A);
        check("d5bc/drop_cnt", 64'(dc5), 64'h0);
        @(posedge clk); #1;
        ordy5 = 5'b11111;
        @(posedge clk); #1;
        @(negedge clk);
        check("d5bc/drained", 64'(ov5), 64'h0);
        @(posedge clk); #1;

        // Five-channel: drops at select 6, counter saturates at 3
        v5 = 1; sel5 = 3'd6; d5 = 8'h66; ordy5 = 5'b00000;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("drop%0d/in_ready", i), 64'(rdy5), 64'h1);
            check($sformatf("drop%0d/out_valid", i), 64'(ov5), 64'h0);
            check($sformatf("drop%0d/drop_cnt", i), 64'(dc5), 64'((i - 1 > 3) ? 3 : i - 1));
            @(posedge clk); #1;
        end
        v5 = 0;
        @(negedge clk);
        check("drop/sat", 64'(dc5), 64'h3);
        @(posedge clk); #1;

        // Async reset with ch0 and ch2 full
        v = 1; sel = 0; d = 8'hC0; ordy = 4'b0000;
        cycle("ar_ch0");
        sel = 2; d = 8'hC2;
        cycle("ar_ch2");
        v = 0;
        cycle("ar_full");
        #2 rst_n = 1'b0;
        #1;
        check("ar/out_valid", 64'(ov), 64'h0);
        check("ar/out_data", 64'(od), 64'h0);
        check("ar/drop_cnt5", 64'(dc5), 64'h0);
        for (int k = 0; k < 4; k++) mq[k].delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        v = 1; sel = 1; d = 8'h7E;
        cycle("ar_new");
        v = 0;
        cycle("ar_out");
        check("ar/ov", 64'(ov), 64'h2);
        check("ar/ch1", 64'(od[15:8]), 64'h7E);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
